cdr_elastic_recovery: RTL

- Parametrised successor to the fixed 10-phase CRD + add/drop FIFO pair on the USB2 receive path.
- Takes SAMPLES oversampled bits per local clock, tracks eye centre with a filtered phase selector, and emits 0/1/2 bits per cycle as drop/add occurs.
- An internal elastic bit FIFO absorbs the variable write rate and returns one bit per clock to the deserialiser.
- New over the fixed version: vote filter, lock indicator, level/sticky status and a synchronous flush.

---
 rtl/cdr_pkg.sv | 16 +
 rtl/bit_elastic_fifo.sv | 81 ++++++++
 rtl/cdr_elastic_recovery.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cdr_pkg.sv
// Shared constants, width helpers and vote encoding for the elastic clock-data-recovery block.
package cdr_pkg;
  localparam int SAMPLES_DEF = 5;
  localparam int DEPTH_DEF   = 41;
  localparam int PREFILL_DEF = DEPTH_DEF / 2;

  function automatic int sel_w(input int samples);
    return $clog2(samples);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {VOTE_NONE, VOTE_UP, VOTE_DOWN} vote_t;
endpackage

// File: rtl/bit_elastic_fifo.sv
// Bit-wide elastic FIFO: accepts 0..2 bits per cycle in time order and returns one bit per cycle
// once PREFILL bits have accumulated.
module bit_elastic_fifo import cdr_pkg::*; #(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PREFILL = DEPTH / 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic [1:0]              wr_cnt,
  input  logic [1:0]              wr_bits,
  output logic                    data_out,
  output logic                    data_valid,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    underflow,
  output logic                    overflow
);
  localparam int LW = lvl_w(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] PRE  = LW'(PREFILL);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_1;
  logic             reading, rd_en, acc0, acc1, ovf_now;
  logic [LW-1:0]    avail, level_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Space is judged after this cycle's read; wr_bits[0] is the earlier bit and is placed first.
  always_comb begin
    rd_en      = reading && (level != '0);
    avail      = level - LW'(rd_en);
    acc0       = (wr_cnt != 2'd0) && (avail < FULL);
    acc1       = (wr_cnt == 2'd2) && ((avail + LW'(acc0)) < FULL);
    ovf_now    = ((wr_cnt != 2'd0) && !acc0) || ((wr_cnt == 2'd2) && !acc1);
    level_next = avail + LW'(acc0) + LW'(acc1);
    wr_ptr_1   = ptr_inc(wr_ptr);
  end

  always_ff @(posedge clock) begin
    if (!flush) begin
      if (acc0) mem[wr_ptr]   <= wr_bits[0];
      if (acc1) mem[wr_ptr_1] <= wr_bits[1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      reading    <= 1'b0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      reading    <= 1'b0;
      data_valid <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (acc0) wr_ptr <= acc1 ? ptr_inc(wr_ptr_1) : wr_ptr_1;
      if (rd_en) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      data_valid <= rd_en;
      if (reading && !rd_en) underflow <= 1'b1;
      if (ovf_now) overflow <= 1'b1;
      level <= level_next;
      if (level >= PRE) reading <= 1'b1;
    end
  end
endmodule

// File: rtl/cdr_elastic_recovery.sv
// Oversampling CDR: picks the eye-centre sample with a vote-filtered phase selector and feeds
// 0/1/2 recovered bits per cycle into an elastic FIFO that returns one bit per cycle.
module cdr_elastic_recovery import cdr_pkg::*; #(
  parameter int SAMPLES     = SAMPLES_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int PREFILL     = DEPTH / 2,
  parameter int VOTE_LEN    = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [SAMPLES-1:0]        samples,
  output logic                      data_out,
  output logic                      data_valid,
  output logic                      locked,
  output logic [sel_w(SAMPLES)-1:0] phase_sel,
  output logic                      add_pulse,
  output logic                      drop_pulse,
  output logic [lvl_w(DEPTH)-1:0]   fifo_level,
  output logic                      underflow,
  output logic                      overflow
);
  localparam int SW  = sel_w(SAMPLES);
  localparam int VW  = $clog2(VOTE_LEN + 1) + 1;
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [SW-1:0]        SEL_RST  = SW'(SAMPLES / 2);
  localparam logic [SW-1:0]        SEL_MAX  = SW'(SAMPLES - 1);
  localparam logic [SW-1:0]        IDEAL    = SW'((SAMPLES + 1) / 2);
  localparam logic [SW-1:0]        S_CONST  = SW'(SAMPLES);
  localparam logic signed [VW-1:0] ONE      = VW'(1);
  localparam logic signed [VW-1:0] UP_LIM   = VW'(VOTE_LEN - 1);
  localparam logic signed [VW-1:0] DN_LIM   = VW'(1 - VOTE_LEN);
  localparam logic [LCW-1:0]       LOCK_MAX = LCW'(LOCK_CYCLES);

  logic signed [VW-1:0] vote_cnt, vote_cnt_next;
  logic [SW-1:0]        sel_next, edge_idx, rel;
  logic [SAMPLES-1:0]   d;
  logic                 edge_found, prev_last, wrap_up_q, wrap_dn_q;
  logic [LCW-1:0]       lock_cnt, lock_next;
  logic [1:0]           wr_cnt, wr_bits;
  vote_t                vote;

  // Lowest transition wins; rel is the edge position measured from the current sample phase.
  always_comb begin
    d          = samples ^ {samples[SAMPLES-2:0], prev_last};
    edge_found = 1'b0;
    edge_idx   = '0;
    for (int i = SAMPLES - 1; i >= 0; i--) begin
      if (d[i]) begin
        edge_found = 1'b1;
        edge_idx   = SW'(i);
      end
    end
    rel = (edge_idx >= phase_sel) ? edge_idx - phase_sel : edge_idx + S_CONST - phase_sel;
    if (!edge_found)                     vote = VOTE_NONE;
    else if (rel == '0 || rel > IDEAL)   vote = VOTE_UP;
    else if (rel < IDEAL)                vote = VOTE_DOWN;
    else                                 vote = VOTE_NONE;
  end

  always_comb begin
    vote_cnt_next = vote_cnt;
    sel_next      = phase_sel;
    case (vote)
      VOTE_UP: begin
        if (vote_cnt == UP_LIM) begin
          vote_cnt_next = '0;
          sel_next      = (phase_sel == SEL_MAX) ? '0 : phase_sel + 1'b1;
        end else vote_cnt_next = vote_cnt + ONE;
      end
      VOTE_DOWN: begin
        if (vote_cnt == DN_LIM) begin
          vote_cnt_next = '0;
          sel_next      = (phase_sel == '0) ? SEL_MAX : phase_sel - 1'b1;
        end else vote_cnt_next = vote_cnt - ONE;
      end
      default: ;
    endcase
    if (sel_next != phase_sel)   lock_next = '0;
    else if (lock_cnt == LOCK_MAX) lock_next = lock_cnt;
    else                         lock_next = lock_cnt + 1'b1;
  end

  // After a down-wrap the previous cycle's last sample was never taken, so it goes in first.
  always_comb begin
    if (wrap_up_q) begin
      wr_cnt  = 2'd0;
      wr_bits = 2'b00;
    end else if (wrap_dn_q) begin
      wr_cnt  = 2'd2;
      wr_bits = {samples[phase_sel], prev_last};
    end else begin
      wr_cnt  = 2'd1;
      wr_bits = {1'b0, samples[phase_sel]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_sel  <= SEL_RST;
      vote_cnt   <= '0;
      prev_last  <= 1'b0;
      lock_cnt   <= '0;
      locked     <= 1'b0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      add_pulse  <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      phase_sel  <= sel_next;
      vote_cnt   <= vote_cnt_next;
      prev_last  <= samples[SAMPLES-1];
      lock_cnt   <= lock_next;
      locked     <= (lock_next == LOCK_MAX);
      wrap_up_q  <= (phase_sel == SEL_MAX) && (sel_next == '0);
      wrap_dn_q  <= (phase_sel == '0) && (sel_next == SEL_MAX);
      add_pulse  <= wrap_dn_q;
      drop_pulse <= wrap_up_q;
    end
  end

  // data_valid qualifies data_out each cycle; the stream has no backpressure.
  bit_elastic_fifo #(.DEPTH(DEPTH), .PREFILL(PREFILL)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_cnt     (wr_cnt),
    .wr_bits    (wr_bits),
    .data_out   (data_out),
    .data_valid (data_valid),
    .level      (fifo_level),
    .underflow  (underflow),
    .overflow   (overflow)
  );
endmodule
